ecc_sign_seq: RTL and testbench

ECC_SIGN_SEQ -- requirements
Module: ecc_sign_seq

---
 rtl/ecc_sign_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_ecc_sign_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_sign_seq.sv
// Signature sequencer over GF(2^M): drives an external point multiplier and field-op unit,
// performs field additions locally as XOR, and reports (r, s) or an abort code.
module ecc_sign_seq #(
    parameter int unsigned M   = 233,
    parameter int unsigned KW  = 13,
    parameter int unsigned TMO = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [KW-1:0] k,
    input  logic [M-1:0]  xg,
    input  logic [M-1:0]  yg,
    input  logic [M-1:0]  hm,
    input  logic [M-1:0]  d,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [M-1:0]  r,
    output logic [M-1:0]  s,
    output logic          pm_req,
    output logic [KW-1:0] pm_k,
    input  logic          pm_ack,
    input  logic [M-1:0]  pm_x,
    input  logic [M-1:0]  pm_y,
    output logic          op_req,
    output logic          op_code,
    output logic [M-1:0]  op_a,
    output logic [M-1:0]  op_b,
    input  logic          op_ack,
    input  logic [M-1:0]  op_res
);

    localparam int unsigned CW = (TMO > 2) ? $clog2(TMO) : 1;

    typedef enum logic [3:0] {
        StIdle, StPmul, StRadd, StMul1, StKadd, StInv, StMul2, StFin, StAbort
    } state_e;

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [KW-1:0]   k_q, k_d;
    logic [M-1:0]    hm_q, hm_d, d_q, d_d;
    logic [M-1:0]    x1_q, x1_d, n1_q, n1_d, n2_q, n2_d, n3_q, n3_d, n4_q, n4_d;
    logic [M-1:0]    r_q, r_d, s_q, s_d;
    logic [M-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            pm_req_q, pm_req_d, op_req_q, op_req_d, op_code_q, op_code_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [M-1:0]    r_new, n1_new, k_ext;
    logic            tmo_hit, go_abort, go_fin;
    logic [1:0]      abort_code;

    // The base point is consumed by the external point multiplier, not by this sequencer.
    logic unused_inputs;
    assign unused_inputs = ^{xg, yg, pm_y};

    assign r_new   = hm_q ^ x1_q;
    assign n1_new  = r_new ^ d_q;
    assign k_ext   = M'(k_q);
    assign tmo_hit = (cnt_q == CW'(TMO - 1));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        k_d        = k_q;
        hm_d       = hm_q;
        d_d        = d_q;
        x1_d       = x1_q;
        n1_d       = n1_q;
        n2_d       = n2_q;
        n3_d       = n3_q;
        n4_d       = n4_q;
        r_d        = r_q;
        s_d        = s_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = 2'd0;
        pm_req_d   = pm_req_q;
        op_req_d   = op_req_q;
        op_code_d  = op_code_q;
        cnt_d      = cnt_q;
        go_abort   = 1'b0;
        go_fin     = 1'b0;
        abort_code = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d      = k;
                    hm_d     = hm;
                    d_d      = d;
                    mode_d   = mode;
                    r_d      = '0;
                    s_d      = '0;
                    busy_d   = 1'b1;
                    pm_req_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StPmul;
                end
            end
            StPmul: begin
                if (pm_ack) begin
                    x1_d     = pm_x;
                    pm_req_d = 1'b0;
                    state_d  = StRadd;
                end else if (tmo_hit) begin
                    go_abort   = 1'b1;
                    abort_code = 2'd3;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRadd: begin
                r_d  = r_new;
                n1_d = n1_new;
                if (r_new == '0) begin
                    go_abort   = 1'b1;
                    abort_code = 2'd1;
                end else if (mode_q) begin
                    go_fin = 1'b1;
                end else if (n1_new == '0) begin
                    go_abort   = 1'b1;
                    abort_code = 2'd2;
                end else begin
                    op_req_d  = 1'b1;
                    op_code_d = 1'b0;
                    op_a_d    = r_new;
                    op_b_d    = d_q;
                    cnt_d     = '0;
                    state_d   = StMul1;
                end
            end
            StMul1, StInv, StMul2: begin
                if (op_ack) begin
                    cnt_d = '0;
                    if (state_q == StMul1) begin
                        n2_d     = op_res;
                        op_req_d = 1'b0;
                        state_d  = StKadd;
                    end else if (state_q == StInv) begin
                        // Multiply follows the inverse back-to-back, so the request stays up.
                        n4_d      = op_res;
                        op_code_d = 1'b0;
                        op_a_d    = op_res;
                        op_b_d    = n3_q;
                        state_d   = StMul2;
                    end else begin
                        s_d    = op_res;
                        go_fin = 1'b1;
                    end
                end else if (tmo_hit) begin
                    go_abort   = 1'b1;
                    abort_code = 2'd3;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StKadd: begin
                n3_d      = k_ext ^ n2_q;
                op_req_d  = 1'b1;
                op_code_d = 1'b1;
                op_a_d    = n1_q;
                op_b_d    = '0;
                cnt_d     = '0;
                state_d   = StInv;
            end
            StFin, StAbort: state_d = StIdle;
            default:        state_d = StIdle;
        endcase

        if (go_fin) begin
            state_d  = StFin;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            op_req_d = 1'b0;
        end
        if (go_abort) begin
            state_d    = StAbort;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = abort_code;
            pm_req_d   = 1'b0;
            op_req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            k_q        <= '0;
            hm_q       <= '0;
            d_q        <= '0;
            x1_q       <= '0;
            n1_q       <= '0;
            n2_q       <= '0;
            n3_q       <= '0;
            n4_q       <= '0;
            r_q        <= '0;
            s_q        <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            pm_req_q   <= 1'b0;
            op_req_q   <= 1'b0;
            op_code_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            k_q        <= k_d;
            hm_q       <= hm_d;
            d_q        <= d_d;
            x1_q       <= x1_d;
            n1_q       <= n1_d;
            n2_q       <= n2_d;
            n3_q       <= n3_d;
            n4_q       <= n4_d;
            r_q        <= r_d;
            s_q        <= s_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            pm_req_q   <= pm_req_d;
            op_req_q   <= op_req_d;
            op_code_q  <= op_code_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign r        = r_q;
    assign s        = s_q;
    assign pm_req   = pm_req_q;
    assign pm_k     = k_q;
    assign op_req   = op_req_q;
    assign op_code  = op_code_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;

endmodule

// File: tb/tb_ecc_sign_seq.sv
// Bench for ecc_sign_seq: mock point-multiply and field-op peers with programmable ack latency,
// directed corner cases plus random transactions checked against a signing-flow model.
module tb_ecc_sign_seq;

    localparam int unsigned M   = 32;
    localparam int unsigned KW  = 13;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, mode = 1'b0;
    logic [KW-1:0] k = '0;
    logic [M-1:0]  xg = '0, yg = '0, hm = '0, d = '0;
    logic          busy, done, err, pm_req, pm_ack, op_req, op_code, op_ack;
    logic [1:0]    err_code;
    logic [M-1:0]  r, s, op_a, op_b, op_res;
    logic [KW-1:0] pm_k;
    logic [M-1:0]  pm_x = '0, pm_y = '0;

    ecc_sign_seq #(.M(M), .KW(KW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .k(k), .xg(xg), .yg(yg), .hm(hm),
        .d(d), .busy(busy), .done(done), .err(err), .err_code(err_code), .r(r), .s(s),
        .pm_req(pm_req), .pm_k(pm_k), .pm_ack(pm_ack), .pm_x(pm_x), .pm_y(pm_y),
        .op_req(op_req), .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_ack(op_ack),
        .op_res(op_res)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    // Peer models: ack after pm_lat/op_lat waiting cycles (0 = same-cycle ack), or never if blocked.
    int pm_lat = 0, op_lat = 0;
    bit pm_block = 1'b0, op_block = 1'b0;
    int pm_cnt = 0, op_cnt = 0;
    int pm_seen = 0, op_seen = 0, op_base = 0, op_req_cycles = 0, done_seen = 0, err_seen = 0;
    logic [KW-1:0] pm_k_log = '0;
    logic          op_code_log [64];
    logic [M-1:0]  op_a_log [64];
    logic [M-1:0]  op_b_log [64];
    logic [M-1:0]  mock [3];
    int            op_idx;

    assign pm_ack = pm_req && !pm_block && (pm_cnt >= pm_lat);
    assign op_ack = op_req && !op_block && (op_cnt >= op_lat);

    always_comb begin
        op_idx = op_seen - op_base;
        op_res = '0;
        if (op_idx >= 0 && op_idx < 3) op_res = mock[op_idx];
    end

    always @(posedge clk) begin
        pm_cnt <= (pm_req && !pm_ack) ? pm_cnt + 1 : 0;
        op_cnt <= (op_req && !op_ack) ? op_cnt + 1 : 0;
        if (pm_ack) begin
            pm_seen  <= pm_seen + 1;
            pm_k_log <= pm_k;
        end
        if (op_ack) begin
            op_code_log[op_seen % 64] <= op_code;
            op_a_log[op_seen % 64]    <= op_a;
            op_b_log[op_seen % 64]    <= op_b;
            op_seen                   <= op_seen + 1;
        end
        if (op_req) op_req_cycles <= op_req_cycles + 1;
        if (done) done_seen <= done_seen + 1;
        if (err) err_seen <= err_seen + 1;
    end

    task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One signing request; blk: 0 = normal, 1 = point multiplier never acks, 2 = field unit never acks.
    task automatic do_txn(input string tag, input logic [KW-1:0] kk, input logic [M-1:0] hh,
                          input logic [M-1:0] dd, input logic [M-1:0] px, input logic md,
                          input logic [M-1:0] m1, input logic [M-1:0] m2,
                          input logic [M-1:0] m3, input int lat, input bit spam,
                          input int blk);
        logic [M-1:0] er, en1, en3, es;
        int ecode, elat, nops, eopc, cyc, b_pm, b_opc, b_done, b_err, i0;

        // Reference: r = hm + x1, n1 = r + d, s = (n1^-1) * (k + r*d), additions as XOR.
        er = hh ^ px;
        en1 = er ^ dd;
        en3 = M'(kk) ^ m1;
        es = '0;
        nops = 0;
        eopc = 0;
        if (blk == 1) begin
            ecode = 3; er = '0; elat = 1 + TMO;
        end else if (er == '0) begin
            ecode = 1; elat = 3 + lat;
        end else if (md) begin
            ecode = 0; elat = 3 + lat;
        end else if (en1 == '0) begin
            ecode = 2; elat = 3 + lat;
        end else if (blk == 2) begin
            ecode = 3; elat = 3 + lat + TMO; eopc = TMO;
        end else begin
            ecode = 0; elat = 7 + 4 * lat; nops = 3; es = m3; eopc = 3 * (lat + 1);
        end

        mock[0] = m1; mock[1] = m2; mock[2] = m3;
        pm_lat = lat; op_lat = lat;
        pm_block = (blk == 1); op_block = (blk == 2);
        pm_x = px; pm_y = $urandom;
        k = kk; hm = hh; d = dd; mode = md; xg = $urandom; yg = $urandom;
        op_base = op_seen; b_pm = pm_seen; b_opc = op_req_cycles;
        b_done = done_seen; b_err = err_seen;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        check({tag, "/busy_rise"}, M'(busy), M'(1));
        start = spam;
        k = KW'($urandom); hm = $urandom; d = $urandom; mode = ~md;
        while (!(done || err) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = spam;
        end
        start = 1'b0;
        check({tag, "/latency"}, M'(cyc), M'(elat));
        check({tag, "/done"}, M'(done), M'(ecode == 0));
        check({tag, "/err"}, M'(err), M'(ecode != 0));
        check({tag, "/err_code"}, M'(err_code), M'(ecode));
        check({tag, "/busy_end"}, M'(busy), M'(0));
        check({tag, "/op_req_end"}, M'(op_req), M'(0));
        check({tag, "/r"}, r, er);
        check({tag, "/s"}, s, es);
        @(negedge clk);
        @(negedge clk);
        check({tag, "/done_pulses"}, M'(done_seen - b_done), M'(ecode == 0));
        check({tag, "/err_pulses"}, M'(err_seen - b_err), M'(ecode != 0));
        check({tag, "/pm_acks"}, M'(pm_seen - b_pm), M'(blk != 1));
        check({tag, "/op_count"}, M'(op_seen - op_base), M'(nops));
        check({tag, "/op_req_cycles"}, M'(op_req_cycles - b_opc), M'(eopc));
        check({tag, "/r_held"}, r, er);
        if (blk != 1) check({tag, "/pm_k"}, M'(pm_k_log), M'(kk));
        if (nops == 3) begin
            i0 = op_base % 64;
            check({tag, "/op0_code"}, M'(op_code_log[i0]), M'(0));
            check({tag, "/op0_a"}, op_a_log[i0], er);
            check({tag, "/op0_b"}, op_b_log[i0], dd);
            check({tag, "/op1_code"}, M'(op_code_log[(i0 + 1) % 64]), M'(1));
            check({tag, "/op1_a"}, op_a_log[(i0 + 1) % 64], en1);
            check({tag, "/op2_code"}, M'(op_code_log[(i0 + 2) % 64]), M'(0));
            check({tag, "/op2_a"}, op_a_log[(i0 + 2) % 64], m2);
            check({tag, "/op2_b"}, op_b_log[(i0 + 2) % 64], en3);
        end
        pm_block = 1'b0;
        op_block = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset/ctrl", M'({busy, done, err, err_code, pm_req, op_req}), M'(0));
        check("reset/r", r, '0);
        check("reset/s", s, '0);
        rst = 1'b0;

        // Reference sign vector, peers ack one cycle late; starts on first cycle out of reset.
        do_txn("sign_lat1", 13'h2, 32'h5, 32'h9, 32'h3, 1'b0, 32'h40, 32'h7, 32'h99, 1, 1'b0, 0);
        do_txn("sign_lat0", 13'h2, 32'h5, 32'h9, 32'h3, 1'b0, 32'h40, 32'h7, 32'h99, 0, 1'b0, 0);
        do_txn("r_only", 13'h1, 32'h5, 32'h9, 32'h3, 1'b1, 32'h1, 32'h2, 32'h3, 0, 1'b0, 0);
        do_txn("r_zero", 13'h1, 32'hA, 32'h9, 32'hA, 1'b0, 32'h1, 32'h2, 32'h3, 0, 1'b0, 0);
        do_txn("n1_zero", 13'h1, 32'h5, 32'h6, 32'h3, 1'b0, 32'h1, 32'h2, 32'h3, 0, 1'b0, 0);
        do_txn("op_tmo", 13'h1, 32'h5, 32'h9, 32'h3, 1'b0, 32'h1, 32'h2, 32'h3, 0, 1'b0, 2);
        do_txn("pm_tmo", 13'h1, 32'h5, 32'h9, 32'h3, 1'b0, 32'h1, 32'h2, 32'h3, 0, 1'b0, 1);
        do_txn("spam", 13'h1abc, 32'h1234, 32'h55aa, 32'h77, 1'b0, 32'hdead, 32'hbeef,
               32'hcafe, 2, 1'b1, 0);

        // Reset while the inverse request is outstanding.
        mock[0] = 32'h40; mock[1] = 32'h7; mock[2] = 32'h99;
        pm_lat = 0; op_lat = 3;
        op_base = op_seen;
        k = 13'h2; hm = 32'h5; d = 32'h9; pm_x = 32'h3; mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!(op_req && op_code) && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid/in_inv", M'(op_req && op_code), M'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid/ctrl", M'({busy, done, err, err_code, pm_req, op_req, op_code}), M'(0));
        check("rst_mid/r", r, '0);
        check("rst_mid/s", s, '0);
        check("rst_mid/op_a", op_a, '0);
        check("rst_mid/pm_k", M'(pm_k), M'(0));
        rst = 1'b0;
        do_txn("after_rst", 13'h2, 32'h5, 32'h9, 32'h3, 1'b0, 32'h40, 32'h7, 32'h99, 0, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            do_txn("rand", KW'($urandom), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), bit'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
